nonuni_dac: RTL and testbench

// - Clocked DAC front-end, inverse of the non-uniform-threshold 3-bit ADC.
// - Accepts 3-bit codes over a valid/ready stream and buffers them in a small FIFO.
// - Maps each code to a non-uniform reconstruction level (midpoint of its ADC threshold bin).
// - Holds each level for a programmable number of cycles; sits between the digital loop and the analog model.

---
 rtl/nonuni_dac_pkg.sv | 23 ++
 rtl/nonuni_dac_fifo.sv | 47 ++++
 rtl/nonuni_dac.sv | 112 +++++++++++
 tb/tb_nonuni_dac.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nonuni_dac_pkg.sv
// Shared types and the reconstruction-level table for the non-uniform 3-bit DAC.
// NONUNI_DAC_XREAL_EN additionally provides the xreal type for the analog output.
package nonuni_dac_pkg;

    typedef logic [2:0] code_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Midpoints of the ADC threshold bins, in millivolts
    localparam int unsigned LEVEL_MV [0:7] = '{250, 800, 1450, 2150, 2850, 3600, 4350, 4850};

`ifdef NONUNI_DAC_XREAL_EN
    typedef real xreal;
`endif

    function automatic int unsigned level_of(input code_t code);
        return LEVEL_MV[code];
    endfunction

endpackage

// File: rtl/nonuni_dac_fifo.sv
// Small synchronous FIFO of DAC codes; pointers carry an extra wrap bit so that
// full and empty are distinguished by the MSB compare.
module nonuni_dac_fifo
    import nonuni_dac_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  code_t wdata,
    input  logic  pop,
    output code_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, rptr_q;
    code_t       mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/nonuni_dac.sv
// Clocked DAC front-end: buffers 3-bit codes and holds each non-uniform level for
// HOLD_CYCLES cycles. NONUNI_DAC_XREAL_EN adds the real-valued dac_out port.
module nonuni_dac
    import nonuni_dac_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned MV_W        = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [2:0]      in_code,
    output logic            in_ready,
    output logic [MV_W-1:0] dac_mv,
    output logic [2:0]      dac_code,
    output logic            dac_upd,
`ifdef NONUNI_DAC_XREAL_EN
    output xreal            dac_out,
`endif
    output logic            busy
);

    localparam int unsigned   CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [MV_W-1:0]   dac_mv_q;
    code_t             dac_code_q;
    logic              dac_upd_q;
    logic              push, pop, full, empty;
    code_t             fifo_rdata;

    // The FIFO is the only source of back-pressure, so ready is simply !full.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    nonuni_dac_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_code),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end else if (!empty) begin
                    pop        = 1'b1;
                    hold_cnt_d = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output level persists after the queue drains; only reset returns it to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            dac_mv_q   <= '0;
            dac_code_q <= '0;
            dac_upd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            dac_upd_q  <= pop;
            if (pop) begin
                dac_code_q <= fifo_rdata;
                dac_mv_q   <= MV_W'(level_of(fifo_rdata));
            end
        end
    end

`ifdef NONUNI_DAC_XREAL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_out <= 0.0;
        end else if (pop) begin
            dac_out <= real'(level_of(fifo_rdata)) * 1.0e-3;
        end
    end
`endif

    assign dac_mv   = dac_mv_q;
    assign dac_code = dac_code_q;
    assign dac_upd  = dac_upd_q;
    assign busy     = (state_q == HOLD) || !empty;

endmodule

// File: tb/tb_nonuni_dac.sv
// Directed bench for nonuni_dac: vector table for a single code, then burst,
// reset-mid-hold and HOLD_CYCLES=1 sequences against hand-computed expectations.
module tb_nonuni_dac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, v1;
    logic [2:0]  in_code, c1;
    logic        in_ready, ready1;
    logic [12:0] dac_mv, mv1;
    logic [2:0]  dac_code, code1;
    logic        dac_upd, upd1;
    logic        busy, busy1;
`ifdef NONUNI_DAC_XREAL_EN
    real         dac_out, out1;
`endif

    int checks   = 0;
    int failures = 0;

    int lv [8] = '{250, 800, 1450, 2150, 2850, 3600, 4350, 4850};

    typedef struct {
        logic       v;
        logic [2:0] c;
        int         mv;
        int         code;
        logic       upd;
        logic       busy;
        logic       ready;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    nonuni_dac #(
        .DEPTH       (4),
        .HOLD_CYCLES (8),
        .MV_W        (13)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_code  (in_code),
        .in_ready (in_ready),
        .dac_mv   (dac_mv),
        .dac_code (dac_code),
        .dac_upd  (dac_upd),
`ifdef NONUNI_DAC_XREAL_EN
        .dac_out  (dac_out),
`endif
        .busy     (busy)
    );

    nonuni_dac #(
        .DEPTH       (4),
        .HOLD_CYCLES (1),
        .MV_W        (13)
    ) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (v1),
        .in_code  (c1),
        .in_ready (ready1),
        .dac_mv   (mv1),
        .dac_code (code1),
        .dac_upd  (upd1),
`ifdef NONUNI_DAC_XREAL_EN
        .dac_out  (out1),
`endif
        .busy     (busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int  occ;
        int  k;
        int  popidx;
        logic acc;
        logic exp_pop;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = '0;
        v1       = 1'b0;
        c1       = '0;

        // single code 3, then a repeat of the same code after returning to idle
        vecs[0] = '{1'b1, 3'd3, 0, 0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 3'd3, 2150, 3, 1'b1, 1'b1, 1'b1};
        for (int i = 2; i <= 8; i++) vecs[i] = '{1'b0, 3'd3, 2150, 3, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 3'd3, 2150, 3, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 3'd3, 2150, 3, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 3'd3, 2150, 3, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 3'd3, 2150, 3, 1'b1, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_mv", dac_mv, 0);
        check("rst_code", dac_code, 0);
        check("rst_upd", dac_upd, 0);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            in_valid = vecs[i].v;
            in_code  = vecs[i].c;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_mv", i), dac_mv, vecs[i].mv);
            check($sformatf("vec%0d_code", i), dac_code, vecs[i].code);
            check($sformatf("vec%0d_upd", i), dac_upd, vecs[i].upd);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_ready", i), in_ready, vecs[i].ready);
        end
        in_valid = 1'b0;

        // burst 0..7 with valid held; pops expected at edges 2, 10, ..., 58
        do_reset();
        occ = 0; k = 0; popidx = 0;
        in_valid = 1'b1;
        in_code  = 3'd0;
        for (int t = 1; t <= 70; t++) begin
            acc = in_valid && (occ != 4);
            @(posedge clk);
            @(negedge clk);
            exp_pop = (t >= 2) && (((t - 2) % 8) == 0) && (popidx < 8);
            occ = occ + int'(acc) - int'(exp_pop);
            if (acc) k++;
            in_valid = (k < 8);
            in_code  = 3'(k);
            check($sformatf("burst_upd_t%0d", t), dac_upd, exp_pop);
            check($sformatf("burst_ready_t%0d", t), in_ready, (occ != 4));
            if (exp_pop) begin
                check($sformatf("burst_mv_%0d", popidx), dac_mv, lv[popidx]);
                check($sformatf("burst_code_%0d", popidx), dac_code, popidx);
                popidx++;
            end
        end
        check("burst_end_busy", busy, 0);
        check("burst_end_mv", dac_mv, 4850);

        // fill with stalled output, then reset mid-hold with codes queued
        do_reset();
        occ = 0; k = 0;
        in_valid = 1'b1;
        in_code  = 3'd6;
        for (int t = 1; t <= 8; t++) begin
            acc = in_valid && (occ != 4);
            @(posedge clk);
            @(negedge clk);
            occ = occ + int'(acc) - int'(t == 2);
            if (acc) k++;
            in_code = 3'(6 - k);
            check($sformatf("fill_ready_t%0d", t), in_ready, (occ != 4));
        end
        check("fill_mv", dac_mv, lv[6]);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_mv", dac_mv, 0);
        check("midrst_code", dac_code, 0);
        check("midrst_upd", dac_upd, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check($sformatf("stale_upd_t%0d", t), dac_upd, 0);
        end
        check("stale_busy", busy, 0);
        check("stale_mv", dac_mv, 0);

        // HOLD_CYCLES=1: codes 1..5 on consecutive edges, one new level per cycle
        v1 = 1'b1;
        c1 = 3'd1;
        for (int t = 1; t <= 8; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (t < 5) c1 = 3'(t + 1);
            else v1 = 1'b0;
            check($sformatf("h1_upd_t%0d", t), upd1, (t >= 2 && t <= 6));
            check($sformatf("h1_busy_t%0d", t), busy1, (t <= 6));
            if (t >= 2 && t <= 6) begin
                check($sformatf("h1_mv_t%0d", t), mv1, lv[t-1]);
                check($sformatf("h1_code_t%0d", t), code1, t - 1);
            end
        end

`ifdef NONUNI_DAC_XREAL_EN
        do_reset();
        check("xr_reset", int'($rtoi(out1 * 1000.0 + 0.5)), 0);
        v1 = 1'b1;
        c1 = 3'd7;
        @(posedge clk);
        @(negedge clk);
        c1 = 3'd0;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        check("xr_code7", int'($rtoi(out1 * 1000.0 + 0.5)), 4850);
        @(posedge clk);
        @(negedge clk);
        check("xr_code0", int'($rtoi(out1 * 1000.0 + 0.5)), 250);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
